// File: rtl/sp_ram_bist_pkg.sv
// Shared types and constants for the single-port RAM March BIST.
// FSM encoding, byte-enable constant and error-counter width.
package sp_ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        FLUSH,
        DONE
    } bist_state_e;

    localparam logic [3:0] BIST_BE_ALL = 4'hF;
    localparam int         ERRCNT_W    = 16;

endpackage

// File: rtl/sp_ram_bist_if.sv
// Single-port RAM request bus: en/addr/wdata/we/be out, rdata back one cycle after a read.
// The BIST is the master; the RAM wrapper (or bench model) is the slave.
interface sp_ram_bist_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  ram_en_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [31:0]           ram_wdata_o;
    logic                  ram_we_o;
    logic [3:0]            ram_be_o;
    logic [31:0]           ram_rdata_i;

    modport master (
        output ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o,
        input  ram_rdata_i
    );

    modport slave (
        input  ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/sp_ram_bist_cmp.sv
// Registered read-compare stage: captures {expected, addr, valid} per read, compares next cycle.
// Sticky error, first-fail address, and a saturating mismatch counter when SP_RAM_BIST_ERRCNT_EN is defined.
module sp_ram_bist_cmp
    import sp_ram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic                  i_clr,
    input  logic                  i_rd,
    input  logic [31:0]           i_exp,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_rdata,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_fail_addr,
    output logic [ERRCNT_W-1:0]   o_err_cnt
);

    logic                  r_vld;
    logic [31:0]           r_exp;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic                  w_mis;

    assign w_mis = r_vld && (i_rdata != r_exp);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_vld       <= 1'b0;
            r_exp       <= '0;
            r_addr      <= '0;
            r_err       <= 1'b0;
            r_fail_addr <= '0;
        end else if (i_clr) begin
            r_vld       <= 1'b0;
            r_err       <= 1'b0;
            r_fail_addr <= '0;
        end else begin
            r_vld  <= i_rd;
            r_exp  <= i_exp;
            r_addr <= i_addr;
            // Only the first mismatch of a run records its address.
            if (w_mis) begin
                r_err <= 1'b1;
                if (!r_err) r_fail_addr <= r_addr;
            end
        end
    end

`ifdef SP_RAM_BIST_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i)                   r_cnt <= '0;
        else if (i_clr)                r_cnt <= '0;
        else if (w_mis && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end

    assign o_err_cnt = r_cnt;
`else
    assign o_err_cnt = '0;
`endif

    assign o_err       = r_err;
    assign o_fail_addr = r_fail_addr;

endmodule

// File: rtl/sp_ram_bist.sv
// March BIST initiator for a single-port RAM (M0 w / M1 r,w~ / M2 desc r~,w / M3 r), optional SP_RAM_BIST_ERRCNT_EN counter.
// A full run takes 6N+2 cycles from start acceptance to done_o, N = RAM_SIZE/4.
module sp_ram_bist
    import sp_ram_bist_pkg::*;
#(
    parameter int          RAM_SIZE   = 32768,
    parameter int          ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BG_PATTERN = 32'h5555_AAAA
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [ERRCNT_W-1:0]   err_cnt_o,
    sp_ram_bist_if.master         ram
);

    localparam int              N       = RAM_SIZE / 4;
    localparam int              WA_W    = ADDR_WIDTH - 2;
    localparam logic [WA_W-1:0] WA_LAST = WA_W'(N - 1);

    bist_state_e           r_state;
    bist_state_e           w_next;
    logic [WA_W-1:0]       r_wa;
    logic                  r_wr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic                  w_last;
    logic                  w_first;
    logic                  w_clr;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_exp;
    logic                  w_err;

    assign w_last  = (r_wa == WA_LAST);
    assign w_first = (r_wa == '0);
    assign w_clr   = (r_state == IDLE) && start_i;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start_i)         w_next = M0;
            M0:      if (w_last)          w_next = M1;
            M1:      if (r_wr && w_last)  w_next = M2;
            M2:      if (r_wr && w_first) w_next = M3;
            M3:      if (w_last)          w_next = FLUSH;
            FLUSH:                        w_next = DONE;
            DONE:                         w_next = IDLE;
            default:                      w_next = IDLE;
        endcase
    end

    // Word address walker; r_wr selects the write half of an M1/M2 read-write pair.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wa <= '0;
            r_wr <= 1'b0;
        end else begin
            unique case (r_state)
                M0: r_wa <= w_last ? '0 : r_wa + 1'b1;
                M1: begin
                    r_wr <= !r_wr;
                    if (r_wr && !w_last) r_wa <= r_wa + 1'b1;
                end
                M2: begin
                    r_wr <= !r_wr;
                    if (r_wr && !w_first) r_wa <= r_wa - 1'b1;
                end
                M3: if (!w_last) r_wa <= r_wa + 1'b1;
                default: begin
                    r_wa <= '0;
                    r_wr <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ram.ram_en_o    = 1'b0;
        ram.ram_we_o    = 1'b0;
        ram.ram_wdata_o = '0;
        w_exp           = BG_PATTERN;
        unique case (r_state)
            M0: begin
                ram.ram_en_o    = 1'b1;
                ram.ram_we_o    = 1'b1;
                ram.ram_wdata_o = BG_PATTERN;
            end
            M1: begin
                ram.ram_en_o    = 1'b1;
                ram.ram_we_o    = r_wr;
                ram.ram_wdata_o = r_wr ? ~BG_PATTERN : '0;
            end
            M2: begin
                ram.ram_en_o    = 1'b1;
                ram.ram_we_o    = r_wr;
                ram.ram_wdata_o = r_wr ? BG_PATTERN : '0;
                w_exp           = ~BG_PATTERN;
            end
            M3: ram.ram_en_o = 1'b1;
            default: ;
        endcase
        ram.ram_addr_o = ram.ram_en_o ? {r_wa, 2'b00} : '0;
        ram.ram_be_o   = ram.ram_en_o ? BIST_BE_ALL : 4'h0;
        w_rd           = ram.ram_en_o && !ram.ram_we_o;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_clr) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (r_state == DONE) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= !w_err;
        end
    end

    sp_ram_bist_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .i_clr       (w_clr),
        .i_rd        (w_rd),
        .i_exp       (w_exp),
        .i_addr      (ram.ram_addr_o),
        .i_rdata     (ram.ram_rdata_i),
        .o_err       (w_err),
        .o_fail_addr (fail_addr_o),
        .o_err_cnt   (err_cnt_o)
    );

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign pass_o = r_pass;

endmodule
